alu_seq: RTL
============

# alu_seq

Parametrised, multi-cycle integer ALU with valid/ready handshakes on both input and output. It is the successor to the combinational integer-operation block. It adds a configurable operand width, status flags, defined divide-by-zero behaviour and iterative divide/power engines. It sits between an operand-issuing controller and a result consumer, and holds one operation in flight at a time.

## Interface
- WIDTH, 32, operand and result width in bits (≥4).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode present.
- in_ready  output  1  block can accept a new operation.
- num1  input  WIDTH  operand a (unsigned).
- num2  input  WIDTH  operand b (unsigned).
- op  input  4  opcode.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- num3  output  WIDTH  result.
- ovf  output  1  carry/borrow/overflow flag.
- err  output  1  divide-by-zero or illegal opcode.

## Operation
- Opcodes:
  - 0: a+b; ovf = carry out.
  - 1: a−b; ovf = borrow (a<b).
  - 2: a*b, low WIDTH bits; ovf = upper WIDTH bits nonzero.
  - 3: a/b (quotient).
  - 4: a%b.
  - 5: a**b, truncated; ovf = any intermediate product exceeds WIDTH bits (sticky).
  - 6: a>>b, logical.
  - 7: a<<b.
- Shifts: if b ≥ WIDTH, result = 0; ovf = 0.
- Divide/modulo with b=0: quotient = all ones, remainder = a, err = 1, ovf = 0. Latency is unchanged.
- Power: 0**0 = 1; a**0 = 1. The exponent is scanned MSB→LSB, one bit per cycle (res←res²; if the bit is set, res←res·a).
- Divide: restoring shift-subtract, one quotient bit per cycle. Opcodes 3 and 4 share the engine.
- Opcodes 8–15: result 0, err = 1, ovf = 0.
- ovf and err are 0 for any opcode not listed as setting them.
- FSM states:
  - IDLE: in_ready=1; on in_valid, latch num1/num2/op. Opcodes 0,1,2,6,7 and illegal opcodes compute and go to DONE. Opcodes 3,4,5 load the engine and go to BUSY.
  - BUSY: step counter runs 0..WIDTH−1; after the last step go to DONE.
  - DONE: out_valid=1; num3/ovf/err are stable. When out_ready=1, go to IDLE.
- Inputs are ignored while not in IDLE. Operands are registered at acceptance, so changing num1/num2/op afterwards has no effect.

## Timing
- Reset (any state, including BUSY or DONE): state=IDLE; in_ready=1; out_valid=0; num3=0; ovf=0; err=0; the step counter clears. Any in-flight operation is discarded with no output.
- Accept happens on the edge where in_valid & in_ready.
- Single-cycle ops (0,1,2,6,7, illegal): out_valid rises on the edge after accept, giving a latency of 1.
- Div/mod/pow: exactly WIDTH BUSY cycles, then DONE, giving a latency of WIDTH+1 cycles. Latency does not depend on the data.
- Output handshake completes on the edge where out_valid & out_ready. out_valid falls and in_ready rises on that edge.
- Throughput: at most one op per 2 cycles (single-cycle ops) or WIDTH+2 cycles (iterative ops).
- in_ready is 0 throughout BUSY and DONE. in_valid asserted at those times is not accepted and must be held by the source.
- Backpressure: DONE holds indefinitely and num3/ovf/err stay unchanged while out_ready=0.
- out_ready asserted while out_valid=0 has no effect.

## Test plan
- WIDTH=8, reset, then op=0 with 200+100 → after 1 cycle, out_valid, num3=44, ovf=1, err=0. Then op=1 with 5−7 → num3=254, ovf=1.
- WIDTH=8, op=3 with 200/7 → out_valid exactly 9 cycles after accept, num3=28. Then op=4 with the same operands → num3=4. Then op=3 with 9/0 → num3=255, err=1.
- WIDTH=8, op=5: 3**4 → num3=81, ovf=0; 3**6 → num3=217 (729 mod 256), ovf=1; 0**0 → num3=1.
- WIDTH=8, op=6 with 128>>3 → 16. op=7 with 1<<8 → 0, ovf=0. op=12 → num3=0, err=1.
- Hold out_ready=0 for 5 cycles after out_valid with in_valid asserted → in_ready stays 0 and num3 stays stable. Raise out_ready → in_ready=1 on the next cycle and the pending op is accepted.
- Assert rst 4 cycles into a WIDTH=8 divide → next cycle in_ready=1, out_valid=0, num3=0. A following 10+1 returns 11 with no stale divide result.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish straight from the inputs; div/mod/pow run WIDTH iterative steps.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] num3,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_POW = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_num3;
  logic             r_ovf;
  logic             r_err;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_pow;
  logic [WIDTH-1:0] r_exp;
  logic             r_povf;

  logic             w_accept;
  logic             w_iter;
  logic             w_last;

  logic [WIDTH:0]   w_sum;
  logic [W2-1:0]    w_mul;
  logic             w_sh_big;
  logic [WIDTH-1:0] w_s_res;
  logic             w_s_ovf;
  logic             w_s_err;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  logic [W2-1:0]    w_sq;
  logic [W2-1:0]    w_pm;
  logic             w_ebit;
  logic [WIDTH-1:0] w_pow_nxt;
  logic             w_povf_nxt;

  logic [WIDTH-1:0] w_it_res;
  logic             w_it_ovf;
  logic             w_it_err;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_iter   = (op == OP_DIV) || (op == OP_MOD) || (op == OP_POW);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // State register; handshake outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_iter ? S_BUSY : S_DONE;
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: single-cycle results plus one divide step and one power step
  always_comb begin
    w_sum    = (WIDTH + 1)'(num1) + (WIDTH + 1)'(num2);
    w_mul    = W2'(num1) * W2'(num2);
    w_sh_big = (num2 >= WIDTH'(WIDTH));
    w_s_res  = '0;
    w_s_ovf  = 1'b0;
    w_s_err  = 1'b0;
    case (op)
      OP_ADD: begin
        w_s_res = w_sum[WIDTH-1:0];
        w_s_ovf = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_s_res = num1 - num2;
        w_s_ovf = (num1 < num2);
      end
      OP_MUL: begin
        w_s_res = w_mul[WIDTH-1:0];
        w_s_ovf = |w_mul[W2-1:WIDTH];
      end
      OP_SHR: w_s_res = w_sh_big ? '0 : (num1 >> num2);
      OP_SHL: w_s_res = w_sh_big ? '0 : (num1 << num2);
      default: w_s_err = 1'b1;
    endcase

    // Partial remainder stays below the divisor, so the diff sign bit is the borrow
    w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    w_diff    = w_rem_sh - {1'b0, r_b};
    w_ge      = ~w_diff[WIDTH];
    w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    w_sq       = W2'(r_pow) * W2'(r_pow);
    w_pm       = W2'(w_sq[WIDTH-1:0]) * W2'(r_a);
    w_ebit     = r_exp[WIDTH-1];
    w_pow_nxt  = w_ebit ? w_pm[WIDTH-1:0] : w_sq[WIDTH-1:0];
    w_povf_nxt = r_povf || (|w_sq[W2-1:WIDTH]) || (w_ebit && (|w_pm[W2-1:WIDTH]));

    w_it_res = w_pow_nxt;
    w_it_ovf = 1'b0;
    w_it_err = 1'b0;
    case (r_op)
      OP_DIV: begin
        w_it_res = w_quo_nxt;
        w_it_err = (r_b == '0);
      end
      OP_MOD: begin
        w_it_res = w_rem_nxt;
        w_it_err = (r_b == '0);
      end
      default: w_it_ovf = w_povf_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num3 <= '0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_pow  <= '0;
      r_exp  <= '0;
      r_povf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= num1;
            r_b    <= num2;
            r_op   <= op;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= num1;
            r_pow  <= WIDTH'(1);
            r_exp  <= num2;
            r_povf <= 1'b0;
            if (!w_iter) begin
              r_num3 <= w_s_res;
              r_ovf  <= w_s_ovf;
              r_err  <= w_s_err;
            end
          end
        end
        S_BUSY: begin
          r_rem  <= w_rem_nxt;
          r_quo  <= w_quo_nxt;
          r_pow  <= w_pow_nxt;
          r_exp  <= r_exp << 1;
          r_povf <= w_povf_nxt;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt  <= '0;
            r_num3 <= w_it_res;
            r_ovf  <= w_it_ovf;
            r_err  <= w_it_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign num3      = r_num3;
  assign ovf       = r_ovf;
  assign err       = r_err;

endmodule
